// File: rtl/contador_pkg.sv
// Shared constants for the contador_param counter family.
package contador_pkg;

  localparam int unsigned MODO_W = 2;

  localparam logic [MODO_W-1:0] MODO_UP   = 2'b00;
  localparam logic [MODO_W-1:0] MODO_DOWN = 2'b01;
  localparam logic [MODO_W-1:0] MODO_STEP = 2'b10;
  localparam logic [MODO_W-1:0] MODO_LOAD = 2'b11;

endpackage

// File: rtl/contador_sig.sv
// Next-value logic: computes the candidate next Q and the overflow/underflow flag.
module contador_sig
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 3
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [MODO_W-1:0] modo,
  input  logic              sat,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  next_q_c,
  output logic              ovf_c
);

  localparam int unsigned SW = WIDTH + 1;

  logic [SW-1:0] sum;
  logic          carry;
  logic          under;

  // Sum is formed one bit wider so the carry out is the overflow flag.
  always_comb begin
    next_q_c = q;
    ovf_c    = 1'b0;
    sum      = '0;
    carry    = 1'b0;
    under    = 1'b0;
    case (modo)
      MODO_UP, MODO_STEP: begin
        sum   = {1'b0, q} + ((modo == MODO_STEP) ? SW'(STEP) : SW'(1));
        carry = sum[WIDTH];
        ovf_c = carry;
        if (carry && sat) next_q_c = '1;
        else              next_q_c = sum[WIDTH-1:0];
      end
      MODO_DOWN: begin
        under = (q == '0);
        ovf_c = under;
        if (under && sat) next_q_c = '0;
        else              next_q_c = q - WIDTH'(1);
      end
      default: begin
        next_q_c = d;
      end
    endcase
  end

endmodule

// File: rtl/contador_param.sv
// Parametrised multi-mode counter with saturate option, RCO pulse and event count.
module contador_param
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 3,
  parameter int unsigned EVW   = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enb,
  input  logic [MODO_W-1:0] modo,
  input  logic              sat,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  output logic              RCO,
  output logic [EVW-1:0]    n_ev
);

  logic [WIDTH-1:0] next_q;
  logic             ovf;
  logic             clamped;
  logic             rco_next;
  logic             clamp_next;

  contador_sig #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_sig (
    .q       (Q),
    .modo    (modo),
    .sat     (sat),
    .d       (D),
    .next_q_c(next_q),
    .ovf_c   (ovf)
  );

  // RCO is suppressed while a saturating clamp is simply being held at the bound.
  always_comb begin
    rco_next   = 1'b0;
    clamp_next = clamped;
    if (enb) begin
      rco_next   = ovf && !(sat && clamped);
      clamp_next = ovf && sat;
    end
  end

  // Q, RCO, clamp tracking and saturating event counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      Q       <= '0;
      RCO     <= 1'b0;
      n_ev    <= '0;
      clamped <= 1'b0;
    end else begin
      RCO     <= rco_next;
      clamped <= clamp_next;
      if (enb) Q <= next_q;
      if (rco_next && (n_ev != '1)) n_ev <= n_ev + EVW'(1);
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Directed self-checking bench for contador_param.
module tb_contador_param;

  logic       clk;
  logic       reset_L;
  logic       enb;
  logic [1:0] modo;
  logic       sat;
  logic [3:0] D;
  logic [3:0] Q;
  logic       RCO;
  logic [3:0] n_ev;

  logic       enb2;
  logic [1:0] modo2;
  logic       sat2;
  logic [1:0] d2;
  logic [1:0] q2;
  logic       rco2;
  logic [3:0] n_ev2;

  int n_tests = 0;
  int n_fail  = 0;

  contador_param #(.WIDTH(4), .STEP(3), .EVW(4)) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .enb    (enb),
    .modo   (modo),
    .sat    (sat),
    .D      (D),
    .Q      (Q),
    .RCO    (RCO),
    .n_ev   (n_ev)
  );

  contador_param #(.WIDTH(2), .STEP(3), .EVW(4)) dut2 (
    .clk    (clk),
    .reset_L(reset_L),
    .enb    (enb2),
    .modo   (modo2),
    .sat    (sat2),
    .D      (d2),
    .Q      (q2),
    .RCO    (rco2),
    .n_ev   (n_ev2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int eq, input int erco, input int enev);
    chk({tag, ".Q"},    32'(Q),    32'(eq));
    chk({tag, ".RCO"},  32'(RCO),  32'(erco));
    chk({tag, ".n_ev"}, 32'(n_ev), 32'(enev));
  endtask

  initial begin
    reset_L = 1'b1;
    enb = 1'b0; modo = 2'b00; sat = 1'b0; D = 4'd0;
    enb2 = 1'b0; modo2 = 2'b00; sat2 = 1'b0; d2 = 2'd0;

    // Power-on reset
    #1 reset_L = 1'b0;
    #1;
    chk3("por", 0, 0, 0);
    tick();
    reset_L = 1'b1;

    // First edge after release counts normally
    enb = 1'b1; modo = 2'b00;
    tick();
    chk3("first_up", 1, 0, 0);

    // Count to 9, then reset between edges
    for (int i = 0; i < 8; i++) tick();
    chk("count9.Q", 32'(Q), 32'd9);
    #2 reset_L = 1'b0;
    #1;
    chk3("mid_reset", 0, 0, 0);
    reset_L = 1'b1;
    tick();
    chk3("after_reset_up", 1, 0, 0);

    // Load then hold
    modo = 2'b11; D = 4'd15;
    tick();
    chk3("load15", 15, 0, 0);
    enb = 1'b0; modo = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3("hold", 15, 0, 0);
    end

    // Up wrap
    enb = 1'b1; modo = 2'b00; sat = 1'b0;
    tick();
    chk3("up_wrap", 0, 1, 1);
    tick();
    chk3("up_after_wrap", 1, 0, 1);

    // Step wrap
    modo = 2'b11; D = 4'd14;
    tick();
    chk3("load14a", 14, 0, 1);
    modo = 2'b10; sat = 1'b0;
    tick();
    chk3("step_wrap", 1, 1, 2);

    // Step saturate, then held clamp
    modo = 2'b11; D = 4'd14;
    tick();
    modo = 2'b10; sat = 1'b1;
    tick();
    chk3("step_sat", 15, 1, 3);
    tick();
    chk3("step_sat_hold", 15, 0, 3);

    // Down underflow wrap
    modo = 2'b11; D = 4'd0; sat = 1'b0;
    tick();
    modo = 2'b01;
    tick();
    chk3("down_wrap", 15, 1, 4);

    // Down underflow saturate
    modo = 2'b11; D = 4'd0;
    tick();
    modo = 2'b01; sat = 1'b1;
    tick();
    chk3("down_sat", 0, 1, 5);
    tick();
    chk3("down_sat_hold", 0, 0, 5);

    // enb=0 right after a wrap clears RCO and holds everything else
    modo = 2'b11; D = 4'd15; sat = 1'b0;
    tick();
    modo = 2'b00;
    tick();
    chk3("wrap_before_dis", 0, 1, 6);
    enb = 1'b0; modo = 2'b11; D = 4'd7;
    tick();
    chk3("disabled", 0, 0, 6);

    // Held up clamp at 15 pulses once
    enb = 1'b1; modo = 2'b11; D = 4'd15;
    tick();
    modo = 2'b00; sat = 1'b1;
    tick();
    chk3("up_clamp", 15, 1, 7);
    tick();
    chk3("up_clamp_hold", 15, 0, 7);

    // Mode change applies on the next edge using current Q
    modo = 2'b01; sat = 1'b0;
    tick();
    chk3("mode_change", 14, 0, 7);

    // Event counter saturation over 20 wraps
    sat = 1'b0;
    for (int i = 0; i < 20; i++) begin
      modo = 2'b11; D = 4'd15;
      tick();
      modo = 2'b00;
      tick();
    end
    chk3("ev_sat", 0, 1, 15);
    modo = 2'b11; D = 4'd15;
    tick();
    modo = 2'b00;
    tick();
    chk3("ev_sat_stay", 0, 1, 15);

    // WIDTH=2 consecutive wraps in step mode: 3 -> 2 -> 1 -> 0 -> 3
    enb = 1'b0;
    enb2 = 1'b1; modo2 = 2'b11; d2 = 2'd3;
    tick();
    chk("w2_load.Q", 32'(q2), 32'd3);
    modo2 = 2'b10; sat2 = 1'b0;
    tick();
    chk("w2_e1.Q", 32'(q2), 32'd2);
    chk("w2_e1.RCO", 32'(rco2), 32'd1);
    tick();
    chk("w2_e2.Q", 32'(q2), 32'd1);
    chk("w2_e2.RCO", 32'(rco2), 32'd1);
    tick();
    chk("w2_e3.Q", 32'(q2), 32'd0);
    chk("w2_e3.RCO", 32'(rco2), 32'd1);
    tick();
    chk("w2_e4.Q", 32'(q2), 32'd3);
    chk("w2_e4.RCO", 32'(rco2), 32'd0);
    chk("w2_e4.n_ev", 32'(n_ev2), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parametrised synchronous multi-mode counter; the next generation of the 4-bit counter, generalised in width, count step and overflow handling.
- Counts up by 1, down by 1 or up by a configurable step, or parallel-loads D, selected by modo.
- Adds a saturate option, a registered one-cycle ripple-carry pulse (RCO) and a saturating count of overflow events.
- Used standalone and cascaded through RCO into wider counters.

Parameters:
- WIDTH, 4, width of D and Q (min 2).
- STEP, 3, increment applied in modo 2'b10 (1 <= STEP < 2**WIDTH).
- EVW, 4, width of the overflow event counter n_ev.

Ports:
- clk  input  1  rising-edge clock; only clock.
- reset_L  input  1  asynchronous, active-low reset.
- enb  input  1  count/load enable.
- modo  input  2  00 up by 1, 01 down by 1, 10 up by STEP, 11 load D.
- sat  input  1  1 = clamp at bound; 0 = wrap modulo 2**WIDTH.
- D  input  WIDTH  parallel load value.
- Q  output  WIDTH  counter value (registered).
- RCO  output  1  registered one-cycle overflow/underflow pulse.
- n_ev  output  EVW  saturating count of RCO pulses since reset.

Behaviour:
- Reset:
  - reset_L=0 asynchronously forces Q=0, RCO=0, n_ev=0 with no clock edge needed, including mid-count.
  - After release, the first rising clk edge operates normally.
- enb=0: Q holds; RCO=0 on the next edge; n_ev holds. modo, D and sat are ignored.
- All updates occur on the rising clk edge when enb=1. Latency is 1 cycle from input to Q/RCO.
- Mode 00:
  - The sum Q+1 is computed at WIDTH+1 bits.
  - If the carry out is 1, Q gets the low WIDTH bits when sat=0, or 2**WIDTH-1 when sat=1.
- Mode 10: same as mode 00 with STEP in place of 1. Example: Q=14, STEP=3 gives 17, so Q=1 when sat=0 and Q=15 when sat=1.
- Mode 01:
  - Q-1; underflow occurs when Q=0.
  - On underflow, Q=2**WIDTH-1 when sat=0, or Q=0 when sat=1.
- Mode 11: Q=D; RCO=0; sat is ignored.
- RCO:
  - Asserts for exactly the cycle following an edge where overflow/underflow was detected.
  - With sat=1, it asserts only if Q was not already at the bound. A held clamp at 15 in up mode pulses once, then RCO=0 on every following edge.
  - It is never high two consecutive cycles unless a fresh wrap occurs each edge. Example: WIDTH=2, STEP=3, wrap mode, Q=3 → 2 → 1 → 0 → 3; RCO is high after every wrapping edge.
- n_ev: increments on each edge that sets RCO=1; saturates at 2**EVW-1; never wraps.
- Simultaneous events:
  - A mode change takes effect on the very next edge using the current Q.
  - Load has priority over everything except enb and reset.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package contador_pkg holds the mode constants MODO_UP=2'b00, MODO_DOWN=2'b01, MODO_STEP=2'b10, MODO_LOAD=2'b11.
- One sub-module, contador_sig, is natural. It is combinational and computes next_q and the ovf flag from Q, modo, sat, D and STEP. The top holds the Q/RCO/n_ev registers and enable/reset logic.

Test Plan (WIDTH=4, STEP=3, EVW=4 unless noted):
- Reset mid-count at Q=9: pull reset_L low between edges → Q=0, RCO=0, n_ev=0 immediately. Release, then modo=00 → Q=1 after first edge.
- Load then hold: enb=1, modo=11, D=4'b1111 → Q=15, RCO=0. Then enb=0 for 3 edges → Q stays 15, RCO=0.
- Up wrap: Q=15, modo=00, sat=0 → Q=0, RCO=1 for one cycle, n_ev=1. Next edge → Q=1, RCO=0.
- Step wrap/saturate: Q=14, modo=10, sat=0 → Q=1, RCO=1. Repeat with sat=1 → Q=15, RCO=1. Next edge → Q=15, RCO=0, n_ev unchanged.
- Down underflow: Q=0, modo=01 with sat=0 → Q=15, RCO=1. With sat=1 → Q=0, RCO=1 once, then 0.
- Event saturation: force 20 wraps in mode 00 → n_ev=15 and stays 15.
